// File: rtl/apb_slave.sv
// Single-cycle APB-style slave: every selected clock edge is a complete transfer.
// The result is a directly addressed register memory with a registered PRDATA and PREADY.
module apb_slave #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 8
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic [ADDRWIDTH-1:0] PADDR,
    input  logic                 PWRITE,
    input  logic                 PSEL,
    input  logic [DATAWIDTH-1:0] PWDATA,
    output logic [DATAWIDTH-1:0] PRDATA,
    output logic                 PREADY
);

    localparam int DEPTH = 2 ** ADDRWIDTH;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        W_ENABLE = 2'b01,
        R_ENABLE = 2'b10
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATAWIDTH-1:0] mem [DEPTH];

    // The next state depends only on the sampled inputs, so the unused
    // encoding 2'b11 also returns to IDLE on the following edge.
    always_comb begin
        // NOTE: assign defaults first in always_comb so no path leaves a signal unassigned and infers a latch.
        state_next = IDLE;
        if (PSEL) begin
            state_next = PWRITE ? W_ENABLE : R_ENABLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state  <= IDLE;
            PREADY <= 1'b0;
        end else begin
            state  <= state_next;
            PREADY <= (state_next != IDLE);
        end
    end

    // NOTE: the memory is built from flops because every word must clear asynchronously on reset; a RAM macro cannot do that.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (PSEL && PWRITE) begin
            mem[PADDR] <= PWDATA;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PRDATA <= '0;
        end else if (PSEL && !PWRITE) begin
            PRDATA <= mem[PADDR];
        end
    end

endmodule

// File: tb/tb_apb_slave.sv
// Testbench for apb_slave: directed scenarios followed by random traffic.
// Every result is compared against a word-array model of the slave memory.
module tb_apb_slave;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic [7:0]  PADDR;
    logic        PWRITE;
    logic        PSEL;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    int vectors    = 0;
    int miscompares = 0;

    logic [31:0] model_mem [256];
    logic [31:0] exp_rdata;

    apb_slave #(.DATAWIDTH(32), .ADDRWIDTH(8)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PADDR   (PADDR),
        .PWRITE  (PWRITE),
        .PSEL    (PSEL),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;
        exp_rdata = 32'h0;
    endtask

    // Called at a falling edge. It drives one cycle of inputs and updates the
    // model at the rising edge. Outputs are checked at the next falling edge.
    task automatic xfer(input logic sel, input logic wr, input logic [7:0] a, input logic [31:0] d);
        logic [1:0] exp_state;
        PSEL   = sel;
        PWRITE = wr;
        PADDR  = a;
        PWDATA = d;
        @(posedge PCLK);
        if (sel && wr)  model_mem[a] = d;
        if (sel && !wr) exp_rdata = model_mem[a];
        exp_state = !sel ? 2'b00 : (wr ? 2'b01 : 2'b10);
        @(negedge PCLK);
        check("pready", {31'b0, PREADY}, {31'b0, sel});
        check("prdata", PRDATA, exp_rdata);
        check("state", {30'b0, dut.state}, {30'b0, exp_state});
    endtask

    initial begin
        PSEL = 1'b0; PWRITE = 1'b0; PADDR = 8'h0; PWDATA = 32'h0;
        PRESETn = 1'b1;
        model_reset();
        #1 PRESETn = 1'b0;
        #2;
        check("rst_pready", {31'b0, PREADY}, 32'h0);
        check("rst_prdata", PRDATA, 32'h0);
        check("rst_state", {30'b0, dut.state}, 32'h0);
        #8 PRESETn = 1'b1;
        @(negedge PCLK);

        // Reads straight after reset return zero.
        for (int i = 0; i < 4; i++) xfer(1'b1, 1'b0, 8'(i), 32'h0);

        // Full-depth write burst, then a full-depth read burst.
        for (int i = 0; i < 256; i++) xfer(1'b1, 1'b1, 8'(i), 32'(i));
        for (int j = 0; j < 256; j++) xfer(1'b1, 1'b0, 8'(j), 32'h0);

        // A deselected cycle must not write, even with PWRITE high.
        xfer(1'b1, 1'b1, 8'h10, 32'hDEADBEEF);
        xfer(1'b0, 1'b1, 8'h10, 32'h12345678);
        xfer(1'b1, 1'b0, 8'h10, 32'h0);
        check("deselect_keep", model_mem[8'h10], 32'hDEADBEEF);

        // Walk the state sequence IDLE, W_ENABLE, R_ENABLE, IDLE.
        xfer(1'b0, 1'b0, 8'h00, 32'h0);
        xfer(1'b1, 1'b1, 8'h30, 32'h0000_0030);
        xfer(1'b1, 1'b0, 8'h30, 32'h0);
        xfer(1'b0, 1'b0, 8'h00, 32'h0);

        // PRDATA holds its value through a later write.
        xfer(1'b1, 1'b1, 8'h05, 32'h0000_0005);
        xfer(1'b1, 1'b0, 8'h05, 32'h0);
        xfer(1'b1, 1'b1, 8'h06, 32'h0000_0066);
        check("prdata_hold", PRDATA, 32'h0000_0005);

        // Assert reset between edges in the middle of a burst.
        xfer(1'b1, 1'b1, 8'h20, 32'hA5A5A5A5);
        xfer(1'b1, 1'b0, 8'h20, 32'h0);
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = 8'h21; PWDATA = 32'hFFFF_FFFF;
        #2 PRESETn = 1'b0;
        #1;
        check("async_pready", {31'b0, PREADY}, 32'h0);
        check("async_prdata", PRDATA, 32'h0);
        model_reset();
        // Hold reset across a selected rising edge; the inputs must be ignored.
        @(posedge PCLK);
        #2;
        check("rst_hold_pready", {31'b0, PREADY}, 32'h0);
        PRESETn = 1'b1;
        @(negedge PCLK);
        xfer(1'b1, 1'b0, 8'h20, 32'h0);
        xfer(1'b1, 1'b0, 8'h21, 32'h0);

        // Random traffic over a small address window so that locations are reused.
        for (int n = 0; n < 400; n++) begin
            logic       sel, wr;
            logic [7:0] a;
            sel = ($urandom_range(3, 0) != 0);
            wr  = $urandom_range(1, 0) == 1;
            a   = 8'($urandom_range(15, 0)) | (($urandom_range(7, 0) == 0) ? 8'hF0 : 8'h00);
            xfer(sel, wr, a, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/apb_slave.md
APB_SLAVE -- requirements
Module: APB_Slave

Interface
REQ-001 Parameter DATAWIDTH, default 32, data bus width in bits.
REQ-002 Parameter ADDRWIDTH, default 8, address bus width in bits; memory depth is 2**ADDRWIDTH words (256).
REQ-003 The port list SHALL be, in this order:
- PCLK  input  1  single clock; all state updates on its rising edge.
- PRESETn  input  1  reset, asynchronous, active-low.
- PADDR  input  ADDRWIDTH  word address of the transfer.
- PWRITE  input  1  1 = write, 0 = read.
- PSEL  input  1  slave select; a transfer is requested on every rising edge where PSEL=1.
- PWDATA  input  DATAWIDTH  write data.
- PRDATA  output  DATAWIDTH  read data, registered.
- PREADY  output  1  transfer-complete indication, registered.
REQ-004 There SHALL be no PENABLE input; each selected cycle is a complete transfer.

Function
REQ-005 Storage SHALL be 2**ADDRWIDTH words of DATAWIDTH bits, addressed directly by PADDR with no decoding, aliasing or out-of-range check.
REQ-006 The control state machine SHALL have three states, encoded IDLE=2'b00, W_ENABLE=2'b01 and R_ENABLE=2'b10.
REQ-007 On each rising edge, the next state SHALL be:
- PSEL=0 -> IDLE.
- PSEL=1 and PWRITE=1 -> W_ENABLE.
- PSEL=1 and PWRITE=0 -> R_ENABLE.
- The transition applies from any state; back-to-back transfers with no idle cycle are allowed.
- The unused encoding 2'b11 SHALL recover to IDLE on the next edge.
REQ-008 Write: on a rising edge with PSEL=1 and PWRITE=1, mem[PADDR] SHALL be loaded with PWDATA; PRDATA is unchanged.
REQ-009 Read: on a rising edge with PSEL=1 and PWRITE=0, PRDATA SHALL be loaded with mem[PADDR], so data is valid one cycle after the address is presented.
REQ-010 PRDATA SHALL hold its last value on all edges that are not reads.
REQ-011 PREADY SHALL be 1 exactly while the state is W_ENABLE or R_ENABLE, and 0 in IDLE; it is registered, never combinational from inputs.
REQ-012 A new address and direction SHALL be accepted every cycle while PSEL stays high; every write in a back-to-back burst is committed and none is dropped.
REQ-013 A read of an address written on an earlier edge SHALL return the written value.
REQ-014 PSEL=0 SHALL cause no memory modification and no PRDATA change, regardless of PWRITE, PADDR or PWDATA.
REQ-015 Inputs SHALL be sampled only at the rising PCLK edge.

Reset
REQ-016 PRESETn=0 SHALL immediately, independent of PCLK, force:
- state = IDLE;
- PREADY = 0;
- PRDATA = 0;
- every memory word = 0.
REQ-017 While PRESETn=0, all inputs SHALL be ignored.
REQ-018 After PRESETn rises, the first rising edge with PSEL=1 SHALL be a normal transfer.
REQ-019 Reset asserted mid-burst SHALL abort the burst; writes committed before reset are cleared by REQ-016.

Verification
REQ-020 Reset then read: PRESETn=0 for 10 ns, then read addresses 0x00..0x03 -> PRDATA=0x00000000 each time and PREADY=1 one cycle after each address.
REQ-021 Full-depth write burst: PSEL held at 1, PWRITE=1, PADDR=i, PWDATA=i for i=0..255 on consecutive cycles, then consecutive reads j=0..255 -> PRDATA=j one cycle after PADDR=j, covering both wrap boundaries 0x00 and 0xFF.
REQ-022 Deselect: write 0xDEADBEEF to 0x10, then PSEL=0 with PWRITE=1, PADDR=0x10, PWDATA=0x12345678 -> PREADY=0 the next cycle, and a later read of 0x10 returns 0xDEADBEEF.
REQ-023 State and PREADY sequence: PSEL pattern 0,1(write),1(read),0 -> state IDLE, W_ENABLE, R_ENABLE, IDLE; PREADY 0,1,1,0.
REQ-024 Asynchronous reset mid-burst: after writing 0xA5A5A5A5 to 0x20, drive PRESETn low between clock edges -> PREADY and PRDATA go to 0 without waiting for a clock edge, and a read of 0x20 after release returns 0.
REQ-025 PRDATA hold: read 0x05 returning 0x00000005, then a write to 0x06 -> PRDATA stays 0x00000005.
